// File: rtl/sap2_pkg.sv
// Shared SAP-2 memory-unit definitions: access FSM encoding, address-map defaults and the
// wait-state counter width (4 bits, which sets the legal WAIT_CYC range of 0..15).
package sap2_pkg;

  localparam int          ADDR_W_DEF  = 16;
  localparam logic [15:0] ROM_END_DEF = 16'h07FF;
  localparam int          CNT_W       = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    WR_WAIT,
    WR_DONE
  } mem_state_t;

endpackage

// File: rtl/memory_unit_mem_array.sv
// Byte-wide single-port storage: the read is combinational and the write happens on the rising
// clock edge. Its contents are never reset.
module mem_array
  import sap2_pkg::*;
#(
  parameter int    ADDR_W    = ADDR_W_DEF,
  parameter string INIT_FILE = ""
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdat,
  output logic [7:0]        rdat
);

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[addr] <= wdat;
    end
  end

  assign rdat = mem[addr];

endmodule

// File: rtl/memory_unit.sv
// Wait-stated memory unit on a shared tri-state data bus. A read reaches ready WAIT_CYC+1 cycles
// after the request edge. Requests made while busy are dropped. Writes at or below ROM_END give wr_err.
module memory_unit
  import sap2_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                WAIT_CYC  = 2,
  parameter logic [ADDR_W-1:0] ROM_END   = ADDR_W'(ROM_END_DEF),
  parameter string             INIT_FILE = ""
) (
  input  logic              CLK,
  input  logic              nCLR,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [7:0]        data,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic              busy,
  output logic              ready,
  output logic              wr_err
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYC);

  mem_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] lat_addr, lat_addr_nxt;
  logic [7:0]        lat_dat, lat_dat_nxt;
  logic [7:0]        rd_dat;
  logic              mem_we;
  logic              drive_en;
  logic              rom_hit;

  mem_array #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_arr (
    .CLK  (CLK),
    .we   (mem_we),
    .addr (lat_addr),
    .wdat (lat_dat),
    .rdat (rd_dat)
  );

  assign rom_hit = (lat_addr <= ROM_END);
  assign data    = drive_en ? rd_dat : 8'bzzzz_zzzz;

  always_ff @(posedge CLK) begin
    if (!nCLR) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The latches only change in IDLE, so they need no reset.
  always_ff @(posedge CLK) begin
    lat_addr <= lat_addr_nxt;
    lat_dat  <= lat_dat_nxt;
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    lat_addr_nxt = lat_addr;
    lat_dat_nxt  = lat_dat;
    busy         = 1'b1;
    ready        = 1'b0;
    wr_err       = 1'b0;
    drive_en     = 1'b0;
    mem_we       = 1'b0;

    case (state)
      IDLE: begin
        busy = 1'b0;
        // Read has priority; a simultaneous write is dropped, not queued.
        if (rd_req) begin
          lat_addr_nxt = addr;
          cnt_nxt      = WAIT_INIT;
          state_nxt    = (WAIT_CYC == 0) ? RD_DRIVE : RD_WAIT;
        end else if (wr_req) begin
          lat_addr_nxt = addr;
          lat_dat_nxt  = data;
          cnt_nxt      = WAIT_INIT;
          state_nxt    = (WAIT_CYC == 0) ? WR_DONE : WR_WAIT;
        end
      end

      RD_WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          state_nxt = RD_DRIVE;
        end
      end

      RD_DRIVE: begin
        drive_en  = 1'b1;
        ready     = 1'b1;
        state_nxt = IDLE;
      end

      WR_WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          state_nxt = WR_DONE;
        end
      end

      WR_DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
        if (rom_hit) begin
          wr_err = 1'b1;
        end else begin
          mem_we = nCLR;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit. It covers a WAIT_CYC=2 instance through an access table plus
// timing, busy-ignore and reset sequences, and a WAIT_CYC=0 instance for zero-wait behaviour.
module tb_memory_unit;
  import sap2_pkg::*;

  logic        CLK = 1'b0;
  logic        nCLR;
  logic [15:0] addr, addr0;
  logic        rd_req, wr_req, rd0, wr0;
  logic        busy, ready, wr_err;
  logic        busy0, ready0, wr_err0;
  logic        tb_drv, tb_drv0;
  logic [7:0]  tb_dat, tb_dat0;
  tri1  [7:0]  data, data0;

  int checks   = 0;
  int failures = 0;

  assign data  = tb_drv  ? tb_dat  : 8'bzzzz_zzzz;
  assign data0 = tb_drv0 ? tb_dat0 : 8'bzzzz_zzzz;

  always #5 CLK = ~CLK;

  memory_unit #(.WAIT_CYC(2)) dut (
    .CLK(CLK), .nCLR(nCLR), .addr(addr), .data(data), .rd_req(rd_req), .wr_req(wr_req),
    .busy(busy), .ready(ready), .wr_err(wr_err)
  );

  memory_unit #(.WAIT_CYC(0)) dut0 (
    .CLK(CLK), .nCLR(nCLR), .addr(addr0), .data(data0), .rd_req(rd0), .wr_req(wr0),
    .busy(busy0), .ready(ready0), .wr_err(wr_err0)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [7:0]  wd;
    logic [7:0]  exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One request on the WAIT_CYC=2 unit; addr/data are scrambled after the latching edge.
  task automatic access(input int idx);
    vec_t v;
    int   n;
    v      = vecs[idx];
    addr   = v.a;
    rd_req = v.rd;
    wr_req = v.wr;
    tb_dat = v.wd;
    tb_drv = v.wr;
    tick();
    rd_req = 1'b0;
    wr_req = 1'b0;
    tb_drv = 1'b0;
    addr   = ~v.a;
    tb_dat = ~v.wd;
    n      = 1;
    while (ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk($sformatf("vec%0d_latency", idx), n, 3);
    chk($sformatf("vec%0d_wr_err", idx), wr_err, v.exp_err);
    if (v.rd) chk($sformatf("vec%0d_rdata", idx), data, v.exp_rd);
    tick();
    chk($sformatf("vec%0d_idle_after", idx), busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    nCLR = 1'b0; addr = '0; addr0 = '0;
    rd_req = 1'b0; wr_req = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
    tb_drv = 1'b0; tb_drv0 = 1'b0; tb_dat = '0; tb_dat0 = '0;
    dut.u_arr.mem[16'h07FF] = 8'hA7;

    //          rd    wr    addr      wdata  exp_rd  exp_err
    vecs[0]  = '{1'b0, 1'b1, 16'h0900, 8'h5A, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 16'h0800, 8'hC3, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 16'h0800, 8'h00, 8'hC3, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 16'h07FF, 8'h11, 8'h00, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 16'h07FF, 8'h00, 8'hA7, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 16'h0A00, 8'h3C, 8'h00, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 16'h0A00, 8'h99, 8'h3C, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 16'h0A00, 8'h00, 8'h3C, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 16'h0B00, 8'h66, 8'h00, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 16'h0A00, 8'h00, 8'h3C, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 16'h0B00, 8'h00, 8'h66, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 16'h07FF, 8'h00, 8'hA7, 1'b0};

    repeat (3) tick();
    chk("reset_busy", busy, 1'b0);
    chk("reset_ready", ready, 1'b0);
    chk("reset_wr_err", wr_err, 1'b0);
    chk("reset_bus_released", data, 8'hFF);
    chk("reset_busy0", busy0, 1'b0);
    nCLR = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) access(i);

    // Read timing at 0x0900: busy in cycles 1-3, ready and data only in cycle 3.
    addr   = 16'h0900;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    addr   = 16'h0A00;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("timing_busy_c%0d", c), busy, (c <= 3));
      chk($sformatf("timing_ready_c%0d", c), ready, (c == 3));
      chk($sformatf("timing_data_c%0d", c), data, (c == 3) ? 8'h5A : 8'hFF);
      tick();
    end

    // Write request while a read is in progress must be ignored.
    addr   = 16'h0900;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    addr   = 16'h0A00;
    wr_req = 1'b1;
    tb_dat = 8'h77;
    tb_drv = 1'b1;
    tick();
    wr_req = 1'b0;
    tb_drv = 1'b0;
    n = 2;
    while (ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("ignore_read_latency", n, 3);
    chk("ignore_read_data", data, 8'h5A);
    tick();
    chk("ignore_idle_after", busy, 1'b0);
    access(9);

    // Reset during WR_WAIT aborts the write to 0x0B00.
    addr   = 16'h0B00;
    wr_req = 1'b1;
    tb_dat = 8'h55;
    tb_drv = 1'b1;
    tick();
    wr_req = 1'b0;
    tb_drv = 1'b0;
    chk("rst_wr_busy", busy, 1'b1);
    nCLR = 1'b0;
    tick();
    nCLR = 1'b1;
    chk("rst_busy_cleared", busy, 1'b0);
    chk("rst_ready_low", ready, 1'b0);
    chk("rst_bus_released", data, 8'hFF);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("rst_no_ready_c%0d", c), ready, 1'b0);
    end
    access(10);
    access(11);

    // Zero wait states: ready one cycle after the request edge, busy-time request dropped.
    addr0   = 16'h0900;
    wr0     = 1'b1;
    tb_dat0 = 8'h5A;
    tb_drv0 = 1'b1;
    tick();
    wr0     = 1'b0;
    tb_drv0 = 1'b0;
    chk("w0_ready", ready0, 1'b1);
    chk("w0_wr_err", wr_err0, 1'b0);
    tick();
    chk("w0_idle", busy0, 1'b0);
    addr0 = 16'h0900;
    rd0   = 1'b1;
    tick();
    chk("r0_ready", ready0, 1'b1);
    chk("r0_busy", busy0, 1'b1);
    chk("r0_data", data0, 8'h5A);
    addr0 = 16'h0A00;
    tick();
    rd0 = 1'b0;
    chk("r0_busy_req_ignored", busy0, 1'b0);
    chk("r0_no_second_ready", ready0, 1'b0);
    tick();
    chk("r0_bus_released", data0, 8'hFF);
    chk("r0_still_idle", busy0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
